// File: rtl/ascon_pkg.sv
// Shared ASCON-128a definitions for the encrypt and decrypt datapaths.
// Widths, round counts, padding byte, round constant and FSM encoding.
package ascon_pkg;

  localparam int STATE_W = 320;
  localparam int RATE_W  = 128;
  localparam int PA      = 12;
  localparam int PB      = 8;

  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AD_PERM,
    ST_CT,
    ST_FIN_PERM,
    ST_OUT
  } state_e;

  function automatic logic [7:0] round_const(
    input logic [3:0] r
  );
    return {4'hF - r, r};
  endfunction

  function automatic logic [2:0] clamp_len(
    input logic [31:0] len
  );
    return (len > 32'd4) ? 3'd4 : len[2:0];
  endfunction

endpackage

// File: rtl/ascon_round.sv
// Single combinational ASCON permutation round.
// Constant addition, bitsliced 5-bit S-box, then the linear layer.
module ascon_round
  import ascon_pkg::*;
(
  input  logic [3:0]         i_idx,
  input  logic [STATE_W-1:0] i_s,
  output logic [STATE_W-1:0] o_s
);

  function automatic logic [63:0] ror(
    input logic [63:0] x,
    input int          n
  );
    return (x >> n) | (x << (64 - n));
  endfunction

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = i_s[319:256];
    x1 = i_s[255:192];
    x2 = i_s[191:128];
    x3 = i_s[127:64];
    x4 = i_s[63:0];
    x2[7:0] = x2[7:0] ^ round_const(i_idx);
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    o_s = {
      x0 ^ ror(x0, 19) ^ ror(x0, 28),
      x1 ^ ror(x1, 61) ^ ror(x1, 39),
      x2 ^ ror(x2, 1)  ^ ror(x2, 6),
      x3 ^ ror(x3, 10) ^ ror(x3, 17),
      x4 ^ ror(x4, 7)  ^ ror(x4, 41)
    };
  end

endmodule

// File: rtl/ascon_decrypt.sv
// Iterative ASCON-128a decrypt/verify core, one round per clock.
// Define ASCON_DEC_PT_MASK_EN to zero pt_out whenever the tag fails.
module ascon_decrypt
  import ascon_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] ini_sin,
  input  logic [127:0]       key,
  input  logic [31:0]        dec_ad,
  input  logic [31:0]        dec_adlen,
  input  logic [31:0]        ct_in,
  input  logic [31:0]        ct_len,
  input  logic [127:0]       tag_in,
  output logic               busy,
  output logic               done,
  output logic [31:0]        pt_out,
  output logic               auth_ok
);

  state_e             r_state;
  logic [STATE_W-1:0] r_s;
  logic [3:0]         r_cnt;
  logic [127:0]       r_key;
  logic [127:0]       r_tag;
  logic [31:0]        r_ct;
  logic [2:0]         r_len;
  logic [31:0]        r_pt;

  logic [2:0]         w_adlen;
  logic [RATE_W-1:0]  w_ad_blk;
  logic [3:0]         w_idx;
  logic [STATE_W-1:0] w_rnd;
  logic [STATE_W-1:0] w_ct_s;
  logic [31:0]        w_pt_raw;
  logic [127:0]       w_tag;
  logic               w_auth;
  logic [31:0]        w_pt_fin;

  assign w_adlen = clamp_len(dec_adlen);
  assign w_idx   = (r_state == ST_AD_PERM) ? r_cnt + 4'd4 : r_cnt;

  ascon_round u_round (
    .i_idx (w_idx),
    .i_s   (r_s),
    .o_s   (w_rnd)
  );

  always_comb begin
    w_ad_blk = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(w_adlen))
        w_ad_blk[127-8*i -: 8] = dec_ad[31-8*i -: 8];
    for (int i = 0; i < 5; i++)
      if (i == int'(w_adlen))
        w_ad_blk[127-8*i -: 8] = PAD_BYTE;
  end

  // Ciphertext replaces the rate bytes it covers (duplex decrypt).
  always_comb begin
    w_ct_s    = r_s;
    w_pt_raw  = '0;
    w_ct_s[0] = ~r_s[0];
    for (int i = 0; i < 4; i++)
      if (i < int'(r_len)) begin
        w_pt_raw[31-8*i -: 8] = r_ct[31-8*i -: 8] ^ r_s[319-8*i -: 8];
        w_ct_s[319-8*i -: 8]  = r_ct[31-8*i -: 8];
      end
    for (int i = 0; i < 5; i++)
      if (i == int'(r_len))
        w_ct_s[319-8*i -: 8] = w_ct_s[319-8*i -: 8] ^ PAD_BYTE;
    w_ct_s[191:64] = w_ct_s[191:64] ^ r_key;
  end

  assign w_tag  = w_rnd[127:0] ^ r_key;
  assign w_auth = (w_tag == r_tag);

`ifdef ASCON_DEC_PT_MASK_EN
  assign w_pt_fin = w_auth ? r_pt : 32'h0;
`else
  assign w_pt_fin = r_pt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_s     <= '0;
      r_cnt   <= '0;
      r_key   <= '0;
      r_tag   <= '0;
      r_ct    <= '0;
      r_len   <= '0;
      r_pt    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pt_out  <= '0;
      auth_ok <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_key <= key;
            r_tag <= tag_in;
            r_ct  <= ct_in;
            r_len <= clamp_len(ct_len);
            r_cnt <= '0;
            busy  <= 1'b1;
            if (w_adlen != 3'd0) begin
              r_s     <= ini_sin ^ {w_ad_blk, 192'b0};
              r_state <= ST_AD_PERM;
            end else begin
              r_s     <= ini_sin;
              r_state <= ST_CT;
            end
          end
        end
        ST_AD_PERM: begin
          r_s <= w_rnd;
          if (r_cnt == 4'(PB - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_CT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_CT: begin
          r_s     <= w_ct_s;
          r_pt    <= w_pt_raw;
          r_cnt   <= '0;
          r_state <= ST_FIN_PERM;
        end
        ST_FIN_PERM: begin
          r_s <= w_rnd;
          if (r_cnt == 4'(PA - 1)) begin
            r_cnt   <= '0;
            pt_out  <= w_pt_fin;
            auth_ok <= w_auth;
            done    <= 1'b1;
            r_state <= ST_OUT;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_OUT: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
